// File: rtl/algo_1r2w_a63_t3_mapmem.sv
// Map-table storage bank for the 1R2W a63 wrapper's t3 port group: NUMPORT masked-write /
// read arrays with modelled read latency, a reset-time init sweep and out-of-range flagging.
module algo_1r2w_a63_t3_mapmem #(
  parameter int               NUMPORT = 3,
  parameter int               WIDTH   = 10,
  parameter int               NUMVROW = 745,
  parameter int               BITVROW = 10,
  parameter int               DELAY   = 1,
  parameter logic [WIDTH-1:0] INITVAL = {WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ready,
  input  logic [NUMPORT-1:0]         t3_writeA,
  input  logic [NUMPORT*BITVROW-1:0] t3_addrA,
  input  logic [NUMPORT*WIDTH-1:0]   t3_dinA,
  input  logic [NUMPORT*WIDTH-1:0]   t3_bwA,
  input  logic [NUMPORT-1:0]         t3_readB,
  input  logic [NUMPORT*BITVROW-1:0] t3_addrB,
  output logic [NUMPORT*WIDTH-1:0]   t3_doutB,
  output logic [NUMPORT-1:0]         t3_vldB,
  output logic [NUMPORT-1:0]         t3_errB
);

  localparam logic [0:0]         ST_INIT  = 1'b0;
  localparam logic [0:0]         ST_READY = 1'b1;
  localparam logic [BITVROW:0]   NROW     = (BITVROW+1)'(NUMVROW);
  localparam logic [BITVROW-1:0] LAST_ROW = BITVROW'(NUMVROW - 1);

  if (DELAY < 1 || DELAY > 4) begin : g_bad_delay
    $error("algo_1r2w_a63_t3_mapmem: DELAY must be within 1..4");
  end

  logic [0:0]         state;
  logic [BITVROW-1:0] row;
  logic               sweeping;
  logic               active;

  assign sweeping = (state == ST_INIT);
  assign active   = (state == ST_READY);

  // Init sweep row counter and INIT -> READY sequencing; ready flips with the last sweep write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      row   <= {BITVROW{1'b0}};
      ready <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (row == LAST_ROW) begin
            state <= ST_READY;
            ready <= 1'b1;
            row   <= {BITVROW{1'b0}};
          end else begin
            state <= ST_INIT;
            ready <= 1'b0;
            row   <= row + BITVROW'(1);
          end
        end
        ST_READY: begin
          state <= ST_READY;
          ready <= 1'b1;
          row   <= {BITVROW{1'b0}};
        end
        default: begin
          state <= ST_INIT;
          ready <= 1'b0;
          row   <= {BITVROW{1'b0}};
        end
      endcase
    end
  end

  for (genvar p = 0; p < NUMPORT; p++) begin : g_port
    logic [WIDTH-1:0]   mem [NUMVROW];
    logic [BITVROW-1:0] waddr;
    logic [BITVROW-1:0] raddr;
    logic [WIDTH-1:0]   wdata;
    logic [WIDTH-1:0]   wmask;
    logic [WIDTH-1:0]   rword;
    logic               wr_ok;
    logic               rd_in_range;
    logic               issue;
    logic [DELAY-1:0]   vld_p;
    logic [DELAY-1:0]   err_p;
    logic [DELAY-1:0]   vld_in;
    logic [DELAY-1:0]   err_in;
    logic [WIDTH-1:0]   data_p  [DELAY];
    logic [WIDTH-1:0]   data_in [DELAY];

    assign waddr = t3_addrA[p*BITVROW +: BITVROW];
    assign raddr = t3_addrB[p*BITVROW +: BITVROW];
    assign wdata = t3_dinA[p*WIDTH +: WIDTH];
    assign wmask = t3_bwA[p*WIDTH +: WIDTH];

    // Request qualification and the array read; out-of-range reads deliver zero.
    always_comb begin
      wr_ok       = active & t3_writeA[p] & ({1'b0, waddr} < NROW);
      rd_in_range = ({1'b0, raddr} < NROW);
      issue       = active & t3_readB[p];
      if (issue && rd_in_range) begin
        rword = mem[raddr];
      end else begin
        rword = {WIDTH{1'b0}};
      end
    end

    // Next-stage inputs of the latency pipeline.
    always_comb begin
      vld_in     = {DELAY{1'b0}};
      err_in     = {DELAY{1'b0}};
      for (int d = 0; d < DELAY; d++) begin
        data_in[d] = {WIDTH{1'b0}};
      end
      vld_in[0]  = issue;
      err_in[0]  = issue & ~rd_in_range;
      data_in[0] = rword;
      for (int d = 1; d < DELAY; d++) begin
        vld_in[d]  = vld_p[d-1];
        err_in[d]  = err_p[d-1];
        data_in[d] = data_p[d-1];
      end
    end

    // Read pipeline; the last data stage only loads on a valid so dout holds between reads.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p <= {DELAY{1'b0}};
        err_p <= {DELAY{1'b0}};
        for (int d = 0; d < DELAY; d++) begin
          data_p[d] <= {WIDTH{1'b0}};
        end
      end else begin
        vld_p <= vld_in;
        err_p <= err_in;
        for (int d = 0; d < DELAY - 1; d++) begin
          data_p[d] <= data_in[d];
        end
        if (vld_in[DELAY-1]) begin
          data_p[DELAY-1] <= data_in[DELAY-1];
        end
      end
    end

    // Array update: sweep fill while initialising, masked port-A writes once ready.
    always_ff @(posedge clk) begin
      if (!rst) begin
        if (sweeping) begin
          mem[row] <= INITVAL;
        end else if (wr_ok) begin
          mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
        end
      end
    end

    assign t3_doutB[p*WIDTH +: WIDTH] = data_p[DELAY-1];
    assign t3_vldB[p]                 = vld_p[DELAY-1];
    assign t3_errB[p]                 = err_p[DELAY-1];
  end

endmodule

// File: tb/tb_algo_1r2w_a63_t3_mapmem.sv
// Bench for algo_1r2w_a63_t3_mapmem: three instances (DELAY 1,2,3) share one stimulus stream
// and are compared every cycle against an array/history model, plus literal spot checks.
module tb_algo_1r2w_a63_t3_mapmem;

  localparam int NP = 3;
  localparam int W  = 10;
  localparam int NV = 745;
  localparam int BV = 10;

  typedef struct packed {
    logic         v;
    logic         e;
    logic [W-1:0] d;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   writeA;
  logic [NP-1:0]   readB;
  logic [NP*BV-1:0] addrA;
  logic [NP*BV-1:0] addrB;
  logic [NP*W-1:0] dinA;
  logic [NP*W-1:0] bwA;

  logic            rdy_i  [3];
  logic [NP*W-1:0] dout_i [3];
  logic [NP-1:0]   vld_i  [3];
  logic [NP-1:0]   err_i  [3];

  int total = 0;
  int bad   = 0;

  // model state
  logic [W-1:0] rmem [NP][NV];
  ent_t         hist [NP][4];
  logic [W-1:0] held [3][NP];
  int           cnt;
  bit           m_ready;
  bit           m_init = 1'b0;

  always #5 clk = ~clk;

  algo_1r2w_a63_t3_mapmem #(.DELAY(1)) u_d1 (
    .clk(clk), .rst(rst), .ready(rdy_i[0]),
    .t3_writeA(writeA), .t3_addrA(addrA), .t3_dinA(dinA), .t3_bwA(bwA),
    .t3_readB(readB), .t3_addrB(addrB),
    .t3_doutB(dout_i[0]), .t3_vldB(vld_i[0]), .t3_errB(err_i[0])
  );

  algo_1r2w_a63_t3_mapmem #(.DELAY(2)) u_d2 (
    .clk(clk), .rst(rst), .ready(rdy_i[1]),
    .t3_writeA(writeA), .t3_addrA(addrA), .t3_dinA(dinA), .t3_bwA(bwA),
    .t3_readB(readB), .t3_addrB(addrB),
    .t3_doutB(dout_i[1]), .t3_vldB(vld_i[1]), .t3_errB(err_i[1])
  );

  algo_1r2w_a63_t3_mapmem #(.DELAY(3)) u_d3 (
    .clk(clk), .rst(rst), .ready(rdy_i[2]),
    .t3_writeA(writeA), .t3_addrA(addrA), .t3_dinA(dinA), .t3_bwA(bwA),
    .t3_readB(readB), .t3_addrB(addrB),
    .t3_doutB(dout_i[2]), .t3_vldB(vld_i[2]), .t3_errB(err_i[2])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each array is a plain memory; hist[p][k] is the read issued k+1 edges ago.
  initial begin : model
    ent_t e;
    int   a;
    int   wa;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_init  = 1'b1;
        cnt     = 0;
        m_ready = 1'b0;
        for (int p = 0; p < NP; p++) begin
          for (int r = 0; r < NV; r++) rmem[p][r] = '0;
          for (int k = 0; k < 4; k++) hist[p][k] = '0;
          for (int i = 0; i < 3; i++) held[i][p] = '0;
        end
      end else begin
        for (int p = 0; p < NP; p++) begin
          a   = int'(addrB[p*BV +: BV]);
          e.v = m_ready && readB[p];
          e.e = e.v && (a >= NV);
          e.d = '0;
          if (e.v && !e.e) e.d = rmem[p][a];
          for (int k = 3; k > 0; k--) hist[p][k] = hist[p][k-1];
          hist[p][0] = e;
          for (int i = 0; i < 3; i++) begin
            if (hist[p][i].v) held[i][p] = hist[p][i].d;
          end
          wa = int'(addrA[p*BV +: BV]);
          if (m_ready && writeA[p] && wa < NV) begin
            rmem[p][wa] = (rmem[p][wa] & ~bwA[p*W +: W]) | (dinA[p*W +: W] & bwA[p*W +: W]);
          end
        end
        cnt++;
        if (cnt >= NV) m_ready = 1'b1;
      end
    end
  end

  // Every-cycle comparison of all three instances against the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (m_init) begin
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("ready d%0d", i + 1), 32'(rdy_i[i]), 32'(m_ready));
          for (int p = 0; p < NP; p++) begin
            chk($sformatf("vld d%0d p%0d", i + 1, p), 32'(vld_i[i][p]), 32'(hist[p][i].v));
            chk($sformatf("err d%0d p%0d", i + 1, p), 32'(err_i[i][p]), 32'(hist[p][i].e));
            chk($sformatf("dout d%0d p%0d", i + 1, p), 32'(dout_i[i][p*W +: W]), 32'(held[i][p]));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    writeA = '0;
    readB  = '0;
  endtask

  task automatic set_wr(input int p, input int a, input logic [W-1:0] d, input logic [W-1:0] m);
    writeA[p]          = 1'b1;
    addrA[p*BV +: BV]  = BV'(a);
    dinA[p*W +: W]     = d;
    bwA[p*W +: W]      = m;
  endtask

  task automatic set_rd(input int p, input int a);
    readB[p]          = 1'b1;
    addrB[p*BV +: BV] = BV'(a);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (rdy_i[0] !== 1'b1 && n < 800) begin
      cyc();
      n++;
    end
    chk("init_len", 32'(n), 32'd745);
  endtask

  initial begin : stim
    rst   = 1'b1;
    idle();
    addrA = '0;
    addrB = '0;
    dinA  = '0;
    bwA   = '0;
    repeat (2) cyc();
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", 32'(rdy_i[i]), 32'd0);
      chk("rst_vld", 32'(vld_i[i]), 32'd0);
      chk("rst_dout", 32'(dout_i[i]), 32'd0);
    end
    rst = 1'b0;
    wait_ready();

    // last row after sweep, port 2
    set_rd(2, 744);
    cyc();
    idle();
    chk("row744_vld", 32'(vld_i[0][2]), 32'd1);
    chk("row744_dout", 32'(dout_i[0][29:20]), 32'h000);

    // masked write
    set_wr(0, 5, 10'h3FF, 10'h3FF);
    cyc();
    set_wr(0, 5, 10'h000, 10'h00F);
    cyc();
    idle();
    set_rd(0, 5);
    cyc();
    idle();
    chk("mask_vld", 32'(vld_i[0][0]), 32'd1);
    chk("mask_dout", 32'(dout_i[0][9:0]), 32'h3F0);

    // read-before-write collision on port 1
    set_wr(1, 7, 10'h155, 10'h3FF);
    set_rd(1, 7);
    cyc();
    writeA = '0;
    chk("coll_old", 32'(dout_i[0][19:10]), 32'h000);
    cyc();
    idle();
    chk("coll_new", 32'(dout_i[0][19:10]), 32'h155);

    // back-to-back reads through the DELAY=3 instance
    set_wr(2, 0, 10'd1, 10'h3FF);
    cyc();
    set_wr(2, 1, 10'd2, 10'h3FF);
    cyc();
    set_wr(2, 2, 10'd3, 10'h3FF);
    cyc();
    idle();
    set_rd(2, 0);
    cyc();
    set_rd(2, 1);
    cyc();
    chk("pipe_early", 32'(vld_i[2][2]), 32'd0);
    set_rd(2, 2);
    cyc();
    idle();
    chk("pipe_v1", 32'(vld_i[2][2]), 32'd1);
    chk("pipe_d1", 32'(dout_i[2][29:20]), 32'd1);
    cyc();
    chk("pipe_v2", 32'(vld_i[2][2]), 32'd1);
    chk("pipe_d2", 32'(dout_i[2][29:20]), 32'd2);
    cyc();
    chk("pipe_v3", 32'(vld_i[2][2]), 32'd1);
    chk("pipe_d3", 32'(dout_i[2][29:20]), 32'd3);
    cyc();
    chk("pipe_end_v", 32'(vld_i[2][2]), 32'd0);
    chk("pipe_hold", 32'(dout_i[2][29:20]), 32'd3);

    // out-of-range read and write
    set_rd(0, 745);
    cyc();
    idle();
    chk("oor_vld", 32'(vld_i[0][0]), 32'd1);
    chk("oor_err", 32'(err_i[0][0]), 32'd1);
    chk("oor_dout", 32'(dout_i[0][9:0]), 32'd0);
    for (int p = 0; p < NP; p++) set_wr(p, 800, 10'h3FF, 10'h3FF);
    cyc();
    idle();
    for (int r = 0; r < NV; r++) begin
      for (int p = 0; p < NP; p++) set_rd(p, r);
      cyc();
    end
    idle();
    repeat (3) cyc();

    // reset while a read is in flight
    set_rd(0, 5);
    cyc();
    chk("pre_rst_dout", 32'(dout_i[0][9:0]), 32'h3F0);
    rst = 1'b1;
    idle();
    cyc();
    chk("rst_drop_vld", 32'(vld_i[1][0]), 32'd0);
    chk("rst_drop_ready", 32'(rdy_i[0]), 32'd0);
    rst = 1'b0;
    wait_ready();
    set_rd(0, 5);
    set_rd(2, 1);
    cyc();
    idle();
    chk("resweep_vld", 32'(vld_i[0]), 32'b101);
    chk("resweep_p0", 32'(dout_i[0][9:0]), 32'h000);
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
